compteur_param_init: RTL
========================

Name: compteur_param_init

Overview:
- Parametrised successor of the ASCON simple up-counter with synchronous init.
- Adds parametric width, programmable load, up/down counting, and wrap or saturate mode.
- Adds a start/run/done sequencer, so the ASCON FSM can launch a bounded count (e.g. p12 rounds 0..11, p6 rounds 6..11) and receive a one-cycle completion pulse.
- Sits beside the ASCON control FSM as round counter and block counter.

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- INIT_VAL, 0, value applied on reset and on init_a_i.
- MODE_WRAP, 1, 1 = modular wrap at the limits, 0 = saturate at the limits.

Ports:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  asynchronous, active-low reset.
- en_i  in  1  count enable; also qualifies init_a_i.
- init_a_i  in  1  synchronous re-init to INIT_VAL; effective only when en_i=1.
- load_i  in  1  synchronous load of load_val_i; honoured only in IDLE.
- load_val_i  in  WIDTH  load and start value.
- up_i  in  1  1 = count up, 0 = count down.
- start_i  in  1  launch a bounded run; honoured only in IDLE.
- end_val_i  in  WIDTH  terminal value of a run; must be stable while busy_o=1.
- data_o  out  WIDTH  current count (registered).
- tc_o  out  1  combinational: busy_o & (data_o==end_val_i).
- busy_o  out  1  1 while state=RUN.
- done_o  out  1  one-cycle pulse (registered) on run completion.

Behaviour:
- Reset (resetb_i=0, async): data_o=INIT_VAL, state=IDLE, busy_o=0, done_o=0, tc_o=0.
- FSM states: IDLE, RUN. busy_o is the registered state bit. done_o defaults to 0 every cycle.
- Priority per rising edge, highest first:
  1. en_i=1 & init_a_i=1: cpt<=INIT_VAL, state<=IDLE. A RUN is aborted with no done_o. This preserves legacy semantics.
  2. IDLE & start_i=1: cpt<=load_val_i, state<=RUN. No step this cycle, regardless of en_i.
  3. IDLE & load_i=1: cpt<=load_val_i, state stays IDLE.
  4. RUN & en_i=1 & cpt==end_val_i: state<=IDLE, done_o<=1, cpt holds (not stepped).
  5. en_i=1: cpt<=step(cpt). Applies in both IDLE (free-running legacy mode) and RUN.
  6. Otherwise: hold.
- Inputs ignored in RUN: start_i and load_i have no effect.
- step() when up_i=1:
  - cpt==2^WIDTH-1: MODE_WRAP=1 gives 0; MODE_WRAP=0 holds.
  - otherwise cpt+1.
- step() when up_i=0:
  - cpt==0: MODE_WRAP=1 gives 2^WIDTH-1; MODE_WRAP=0 holds.
  - otherwise cpt-1.
- An unreachable end_val_i with saturate mode leaves RUN until init or reset. This is permitted; the caller is responsible.
- Run latency: from the start edge with en_i held at 1, done_o is high during the cycle after edge N+1, where N=|end_val_i - load_val_i| (no wrap). load_val_i==end_val_i gives done_o after the 2nd edge.
- en_i low during RUN pauses the count. The terminal check is also gated by en_i.
- done_o and busy_o=0 take effect on the same edge. The next start_i may be accepted on the cycle done_o is high.
- Async reset mid-run: immediate return to the reset state; no done_o.

Decomposition:
- ascon_pack holds:
  - typedef enum logic {CPT_IDLE, CPT_RUN} cpt_state_t.
  - Constants ROUND_START_A=4'd0, ROUND_START_B=4'd6, ROUND_END=4'd11.
- Single module, no sub-module. step() is a local function.

Test Plan:
- Reset: hold resetb_i=0 with random inputs -> data_o=0, busy_o=0, done_o=0. Release, en_i=1, up_i=1, 3 edges -> data_o=3.
- p12 run: load_val_i=0, end_val_i=11, start_i pulse, en_i=1 -> data_o 0..11, tc_o=1 only when data_o=11. done_o high exactly 1 cycle after edge 13; busy_o=0 from then; data_o stays 11.
- p6 run with pause: load_val_i=6, end_val_i=11, en_i low 2 cycles after data_o=8 -> data_o holds 8. done_o delayed by 2 cycles versus an unpaused run.
- Wrap/saturate, WIDTH=4, free mode: MODE_WRAP=1, data_o=15, up_i=1 -> 0; data_o=0, up_i=0 -> 15. MODE_WRAP=0: stays 15, stays 0.
- Priority: en_i=1, init_a_i=1 while RUN at data_o=5 -> data_o=0, busy_o=0, no done_o. In IDLE, start_i and load_i together with load_val_i=9 -> RUN, data_o=9. load_i during RUN -> ignored.
- Async reset mid-run at data_o=7 -> data_o=0, busy_o=0 immediately, done_o never asserted.

Source files
------------

// File: rtl/ascon_pack.sv
// ascon_pack: shared types and round constants for the ASCON control path.
`default_nettype none

package ascon_pack;

  typedef enum logic {CPT_IDLE, CPT_RUN} cpt_state_t;

  localparam logic [3:0] ROUND_START_A = 4'd0;
  localparam logic [3:0] ROUND_START_B = 4'd6;
  localparam logic [3:0] ROUND_END     = 4'd11;

endpackage

`default_nettype wire

// File: rtl/compteur_param_init.sv
// compteur_param_init: parametric up/down counter with wrap/saturate, load and a start/run/done sequencer.
`default_nettype none

module compteur_param_init
  import ascon_pack::*;
#(
  parameter int WIDTH     = 4,
  parameter int INIT_VAL  = 0,
  parameter int MODE_WRAP = 1
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             en_i,
  input  logic             init_a_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] end_val_i,
  output logic [WIDTH-1:0] data_o,
  output logic             tc_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VAL);

  cpt_state_t       state, state_nxt;
  logic [WIDTH-1:0] cpt, cpt_nxt;
  logic             done, done_nxt;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic up);
    logic [WIDTH-1:0] r;
    r = v;
    if (up) begin
      if (v == {WIDTH{1'b1}}) r = (MODE_WRAP != 0) ? '0 : v;
      else                    r = v + WIDTH'(1);
    end else begin
      if (v == '0) r = (MODE_WRAP != 0) ? {WIDTH{1'b1}} : v;
      else         r = v - WIDTH'(1);
    end
    return r;
  endfunction

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state <= CPT_IDLE;
      cpt   <= INIT_V;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cpt   <= cpt_nxt;
      done  <= done_nxt;
    end
  end

  // Legacy init outranks everything so an in-flight run can always be aborted.
  always_comb begin
    state_nxt = state;
    cpt_nxt   = cpt;
    done_nxt  = 1'b0;
    if (en_i && init_a_i) begin
      cpt_nxt   = INIT_V;
      state_nxt = CPT_IDLE;
    end else if (state == CPT_IDLE && start_i) begin
      cpt_nxt   = load_val_i;
      state_nxt = CPT_RUN;
    end else if (state == CPT_IDLE && load_i) begin
      cpt_nxt   = load_val_i;
    end else if (state == CPT_RUN && en_i && cpt == end_val_i) begin
      state_nxt = CPT_IDLE;
      done_nxt  = 1'b1;
    end else if (en_i) begin
      cpt_nxt   = step(cpt, up_i);
    end
  end

  assign data_o = cpt;
  assign busy_o = (state == CPT_RUN);
  assign done_o = done;
  assign tc_o   = busy_o & (cpt == end_val_i);

endmodule

`default_nettype wire
